// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite memory write path.
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 13;
    localparam int SPRITE_DATA_W = 16;

    typedef logic [SPRITE_DATA_W-1:0] rgb565_t;

    // Magenta colour key used by the optional transparent-skip build
    localparam rgb565_t TRANSP_KEY_DEF = 16'hF81F;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BLANK = 2'd1,
        ST_DRAIN      = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sprite_mem_writer_if.sv
// CPU/loader command port of the sprite memory writer (valid/ready handshake).
interface sprite_mem_writer_if
    import sprite_pkg::*;
#(
    parameter int DATA_WIDTH = SPRITE_DATA_W
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_is_addr;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_is_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_is_addr,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/sprite_wr_fifo.sv
// Synchronous first-word-fall-through FIFO of pending {addr, data} sprite writes.
module sprite_wr_fifo
    import sprite_pkg::*;
#(
    parameter int ENTRY_W = SPRITE_ADDR_W + SPRITE_DATA_W,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_idx_r;
    logic [PTR_W-1:0]   rd_idx_r;
    logic [CNT_W-1:0]   count_r;
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic               push_s;
    logic               pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign head   = mem_r[rd_idx_r];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_r <= {PTR_W{1'b0}};
            rd_idx_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_idx_r <= wr_idx_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_idx_r <= rd_idx_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_idx_r] <= push_entry;
        end
    end

endmodule

// File: rtl/sprite_mem_writer.sv
// Sprite memory write front end: queues CPU writes and commits them only during blanking.
// Build option: SPRITE_SKIP_TRANSPARENT_EN drops data words equal to TRANSP_KEY.
module sprite_mem_writer
    import sprite_pkg::*;
#(
    parameter int              ADDR_WIDTH = SPRITE_ADDR_W,
    parameter int              DATA_WIDTH = SPRITE_DATA_W,
    parameter int              FIFO_DEPTH = 16,
    parameter [DATA_WIDTH-1:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic                  pix_clk,
    input  logic                  reset,
    sprite_mem_writer_if.slave    cmd,
    input  logic                  bright,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  overflow
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
`ifdef SPRITE_SKIP_TRANSPARENT_EN
    localparam bit SKIP_KEY = 1'b1;
`else
    localparam bit SKIP_KEY = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic                  overflow_r;
    wr_state_t             state_r;
    wr_state_t             state_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  full_s;
    logic                  empty_s;
    logic [ENTRY_W-1:0]    head_s;

    assign cmd.cmd_ready = !full_s;
    assign accept_s      = cmd.cmd_valid && !full_s;
    // Keyed pixels still consume an address so the underlying memory shows through
    assign push_s        = accept_s && !cmd.cmd_is_addr &&
                           !(SKIP_KEY && (cmd.cmd_data == TRANSP_KEY));
    assign busy          = !empty_s;
    assign overflow      = overflow_r;

    sprite_wr_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk        (pix_clk),
        .rst        (reset),
        .push       (push_s),
        .push_entry ({wr_ptr_r, cmd.cmd_data}),
        .pop        (mem_we),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Write pointer and sticky overflow flag
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                if (cmd.cmd_is_addr) begin
                    wr_ptr_r <= cmd.cmd_data[ADDR_WIDTH-1:0];
                end else begin
                    wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
                end
            end
            if (cmd.cmd_valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Drain state register
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state; the write strobe is the combinational DRAIN decision so bright gates it at once
    always_comb begin
        state_s   = state_r;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE, ST_WAIT_BLANK, ST_DRAIN: begin
                if (empty_s) begin
                    state_s = ST_IDLE;
                end else if (bright) begin
                    state_s = ST_WAIT_BLANK;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        mem_we = (state_s == ST_DRAIN);
        if (!empty_s) begin
            mem_addr  = head_s[ENTRY_W-1 -: ADDR_WIDTH];
            mem_wdata = head_s[DATA_WIDTH-1:0];
        end else begin
            mem_addr  = {ADDR_WIDTH{1'b0}};
            mem_wdata = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Directed self-checking bench for sprite_mem_writer; committed writes are logged at negedge.
module tb_sprite_mem_writer;

    logic        pix_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        bright  = 1'b0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        overflow;

    sprite_mem_writer_if cmd_if ();

    sprite_mem_writer dut (
        .pix_clk   (pix_clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .bright    (bright),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #20 pix_clk = ~pix_clk;

    int cyc = 0;
    always @(posedge pix_clk) cyc <= cyc + 1;

    logic [12:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];

    // A strobe visible mid-cycle commits on the next edge (inputs only change just after edges)
    always @(negedge pix_clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pix_clk);
            #1;
        end
    endtask

    task automatic send(input logic is_addr, input logic [15:0] d);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_is_addr = is_addr;
        cmd_if.cmd_data    = d;
        step(1);
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_is_addr = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [12:0] a, input logic [15:0] d);
        logic [31:0] ga;
        logic [31:0] gd;
        if (idx < log_addr.size()) begin
            ga = {19'd0, log_addr[idx]};
            gd = {16'd0, log_data[idx]};
        end else begin
            ga = 32'hFFFF_FFFF;
            gd = 32'hFFFF_FFFF;
        end
        check_eq({tag, "_addr"}, ga, {19'd0, a});
        check_eq({tag, "_data"}, gd, {16'd0, d});
    endtask

    task automatic check_gap(input string tag, input int first, input int last, input int exp);
        int g;
        if (log_cyc.size() > last) g = log_cyc[last] - log_cyc[first];
        else g = -1;
        check_eq(tag, g, exp);
    endtask

    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_is_addr = 1'b0;
        cmd_if.cmd_data    = 16'h0000;

        // Reset state
        step(2);
        check_eq("rst_ready", cmd_if.cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_ovf", overflow, 0);
        reset = 1'b0;
        step(1);
        clear_log();

        // 1: three words during blanking
        send(1'b1, 16'h0100);
        send(1'b0, 16'hA0A0);
        #1;
        check_eq("t1_lat_we", mem_we, 1);
        check_eq("t1_lat_addr", mem_addr, 16'h0100);
        check_eq("t1_lat_data", mem_wdata, 16'hA0A0);
        send(1'b0, 16'hB0B0);
        send(1'b0, 16'hC0C0);
        step(3);
        check_eq("t1_count", log_addr.size(), 3);
        check_log("t1_w0", 0, 13'h0100, 16'hA0A0);
        check_log("t1_w1", 1, 13'h0101, 16'hB0B0);
        check_log("t1_w2", 2, 13'h0102, 16'hC0C0);
        check_gap("t1_gap", 0, 2, 2);
        check_eq("t1_busy", busy, 0);

        // 2: queue during active video, drain in blanking
        clear_log();
        bright = 1'b1;
        send(1'b1, 16'h0200);
        for (int i = 0; i < 5; i++) send(1'b0, 16'h2000 + 16'(i));
        step(2);
        check_eq("t2_we_hold", mem_we, 0);
        check_eq("t2_busy_hold", busy, 1);
        check_eq("t2_nolog", log_addr.size(), 0);
        bright = 1'b0;
        #1;
        check_eq("t2_we_go", mem_we, 1);
        step(5);
        check_eq("t2_busy_end", busy, 0);
        check_eq("t2_count", log_addr.size(), 5);
        for (int i = 0; i < 5; i++)
            check_log($sformatf("t2_w%0d", i), i, 13'h0200 + 13'(i), 16'h2000 + 16'(i));
        check_gap("t2_gap", 0, 4, 4);

        // 3: overflow on the 17th word
        clear_log();
        bright = 1'b1;
        send(1'b1, 16'h0300);
        for (int i = 0; i < 16; i++) send(1'b0, 16'h3000 + 16'(i));
        check_eq("t3_ready_full", cmd_if.cmd_ready, 0);
        check_eq("t3_ovf_pre", overflow, 0);
        send(1'b0, 16'h3010);
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_busy", busy, 1);
        bright = 1'b0;
        step(17);
        check_eq("t3_count", log_addr.size(), 16);
        check_log("t3_first", 0, 13'h0300, 16'h3000);
        check_log("t3_last", 15, 13'h030F, 16'h300F);
        check_eq("t3_ovf_sticky", overflow, 1);
        check_eq("t3_ready_back", cmd_if.cmd_ready, 1);

        // 4: address wrap
        clear_log();
        send(1'b1, 16'h1FFF);
        send(1'b0, 16'h4444);
        send(1'b0, 16'h5555);
        step(3);
        check_eq("t4_count", log_addr.size(), 2);
        check_log("t4_w0", 0, 13'h1FFF, 16'h4444);
        check_log("t4_w1", 1, 13'h0000, 16'h5555);

        // 5: active video interrupts a drain; address cmd while waiting
        clear_log();
        bright = 1'b1;
        send(1'b1, 16'h0500);
        for (int i = 0; i < 8; i++) send(1'b0, 16'h6000 + 16'(i));
        bright = 1'b0;
        step(3);
        bright = 1'b1;
        #1;
        check_eq("t5_we_stop", mem_we, 0);
        send(1'b1, 16'h0700);
        step(3);
        check_eq("t5_partial", log_addr.size(), 3);
        check_eq("t5_we_wait", mem_we, 0);
        check_eq("t5_busy_wait", busy, 1);
        bright = 1'b0;
        step(5);
        check_eq("t5_count", log_addr.size(), 8);
        for (int i = 0; i < 8; i++)
            check_log($sformatf("t5_w%0d", i), i, 13'h0500 + 13'(i), 16'h6000 + 16'(i));
        send(1'b0, 16'h7777);
        step(2);
        check_log("t5_newptr", 8, 13'h0700, 16'h7777);

        // 6: reset with queued writes
        clear_log();
        bright = 1'b1;
        send(1'b1, 16'h0600);
        for (int i = 0; i < 4; i++) send(1'b0, 16'h8000 + 16'(i));
        step(1);
        check_eq("t6_busy_q", busy, 1);
        bright = 1'b0;
        #1;
        check_eq("t6_we_pre", mem_we, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_we_rst", mem_we, 0);
        check_eq("t6_busy_rst", busy, 0);
        check_eq("t6_ovf_rst", overflow, 0);
        step(2);
        reset = 1'b0;
        step(4);
        check_eq("t6_nolog", log_addr.size(), 0);
        check_eq("t6_busy_end", busy, 0);

        // Transparent key handling
        clear_log();
        send(1'b1, 16'h0020);
        send(1'b0, 16'hF81F);
        send(1'b0, 16'h1234);
        step(3);
`ifdef SPRITE_SKIP_TRANSPARENT_EN
        check_eq("key_count", log_addr.size(), 1);
        check_log("key_next", 0, 13'h0021, 16'h1234);
`else
        check_eq("key_count", log_addr.size(), 2);
        check_log("key_w0", 0, 13'h0020, 16'hF81F);
        check_log("key_w1", 1, 13'h0021, 16'h1234);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
